// File: rtl/craps_round_sequencer.sv
// ---------------------------------------------------------------------------
// craps_round_sequencer
//
// Runs one game of craps from a raw push-button and two free-running dice
// counters. The button is synchronised and debounced. Each accepted press
// captures both dice. The captured roll is then evaluated against the
// come-out or point rules on the following cycle.
//
// Parameters
//   SYNC_STAGES     flops on the raw roll input (minimum 2)
//   DEBOUNCE_CYCLES consecutive differing synchronised cycles needed before
//                   the debounced level follows (minimum 1)
//   CNT_W           width of the saturating per-game roll counter
//
// Ports
//   clock       rising-edge system clock
//   reset       asynchronous active-low reset
//   roll        raw push-button, active-high, asynchronous
//   die_a/die_b dice counter values, legal range 1..6
//   disp_a/b    latched dice for the 7-segment decoders (7 = blank)
//   point       current point, 0 when none is set
//   phase       00 come-out, 01 point, 10 win, 11 lose
//   win/loss    game outcome LEDs
//   busy        high during the one-cycle evaluation state
//   bad_sample  one-cycle pulse when a press is rejected for illegal dice
//   roll_count  accepted rolls in the current game, saturating
//
// Optional feature (macro CRAPS_STATS_EN)
//   Adds games_won / games_lost. These are saturating 8-bit counters that
//   are cleared only by reset. Each one increments on entry to WIN or LOSE.
// ---------------------------------------------------------------------------
module craps_round_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             roll,
    input  logic [2:0]       die_a,
    input  logic [2:0]       die_b,
    output logic [2:0]       disp_a,
    output logic [2:0]       disp_b,
    output logic [3:0]       point,
    output logic [1:0]       phase,
    output logic             win,
    output logic             loss,
    output logic             busy,
    output logic             bad_sample,
    output logic [CNT_W-1:0] roll_count
`ifdef CRAPS_STATS_EN
    ,
    output logic [7:0]       games_won,
    output logic [7:0]       games_lost
`endif
);

    // -----------------------------------------------------------------------
    // Local types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_COMEOUT = 3'd0,
        ST_POINT   = 3'd1,
        ST_EVAL    = 3'd2,
        ST_WIN     = 3'd3,
        ST_LOSE    = 3'd4
    } state_t;

    localparam logic [1:0] PH_COMEOUT = 2'b00;
    localparam logic [1:0] PH_POINT   = 2'b01;
    localparam logic [1:0] PH_WIN     = 2'b10;
    localparam logic [1:0] PH_LOSE    = 2'b11;

    localparam logic [2:0] BLANK = 3'd7;

    // The debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -----------------------------------------------------------------------
    // Input synchroniser: a plain shift chain. Bit 0 takes the raw button.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], roll};
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Debouncer
    // The counter tracks how many consecutive cycles the synchronised input
    // has disagreed with the accepted level. The level flips at the end of
    // the cycle in which the count reaches DEBOUNCE_CYCLES. press_pulse is
    // raised in that same cycle for a rising flip. The controller therefore
    // captures the dice on the very edge where the level becomes 1, and no
    // extra edge-detect register is needed.
    // -----------------------------------------------------------------------
    logic            deb_level_reg;
    logic [DB_W-1:0] deb_cnt_reg;
    logic            deb_flip;
    logic            press_pulse;

    assign deb_flip    = (sync_out != deb_level_reg) && (deb_cnt_reg == DB_LAST);
    assign press_pulse = deb_flip && sync_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_level_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else if (sync_out == deb_level_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_flip) begin
            deb_level_reg <= sync_out;
            deb_cnt_reg   <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + DB_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Roll qualification (combinational, only used in the press cycle)
    // -----------------------------------------------------------------------
    logic       dice_ok;
    logic [3:0] sum_next;

    assign dice_ok  = (die_a != 3'd0) && (die_a != 3'd7) &&
                      (die_b != 3'd0) && (die_b != 3'd7);
    assign sum_next = {1'b0, die_a} + {1'b0, die_b};

    // -----------------------------------------------------------------------
    // Game controller: one always_ff, every output registered
    // -----------------------------------------------------------------------
    state_t           state_reg;
    logic [3:0]       sum_reg;
    logic [2:0]       disp_a_reg;
    logic [2:0]       disp_b_reg;
    logic [3:0]       point_reg;
    logic [1:0]       phase_reg;
    logic             win_reg;
    logic             loss_reg;
    logic             busy_reg;
    logic             bad_sample_reg;
    logic [CNT_W-1:0] roll_count_reg;
`ifdef CRAPS_STATS_EN
    logic [7:0]       games_won_reg;
    logic [7:0]       games_lost_reg;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_COMEOUT;
            sum_reg        <= 4'd0;
            disp_a_reg     <= BLANK;
            disp_b_reg     <= BLANK;
            point_reg      <= 4'd0;
            phase_reg      <= PH_COMEOUT;
            win_reg        <= 1'b0;
            loss_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            bad_sample_reg <= 1'b0;
            roll_count_reg <= '0;
`ifdef CRAPS_STATS_EN
            games_won_reg  <= 8'd0;
            games_lost_reg <= 8'd0;
`endif
        end else begin
            bad_sample_reg <= 1'b0;

            case (state_reg)
                ST_COMEOUT, ST_POINT, ST_WIN, ST_LOSE: begin
                    if (press_pulse) begin
                        if (!dice_ok) begin
                            // Rejected press: nothing is captured.
                            bad_sample_reg <= 1'b1;
                        end else begin
                            disp_a_reg <= die_a;
                            disp_b_reg <= die_b;
                            sum_reg    <= sum_next;
                            busy_reg   <= 1'b1;
                            state_reg  <= ST_EVAL;
                            if (state_reg == ST_WIN || state_reg == ST_LOSE) begin
                                // A press after a finished game opens a new
                                // game. Phase drops to come-out here so that
                                // the evaluation applies come-out rules.
                                point_reg      <= 4'd0;
                                win_reg        <= 1'b0;
                                loss_reg       <= 1'b0;
                                phase_reg      <= PH_COMEOUT;
                                roll_count_reg <= CNT_ONE;
                            end else if (roll_count_reg != CNT_MAX) begin
                                roll_count_reg <= roll_count_reg + CNT_ONE;
                            end
                        end
                    end
                end

                ST_EVAL: begin
                    // Presses that land here are dropped on purpose.
                    busy_reg <= 1'b0;
                    if (phase_reg == PH_POINT) begin
                        if (sum_reg == point_reg) begin
                            state_reg <= ST_WIN;
                            phase_reg <= PH_WIN;
                            win_reg   <= 1'b1;
`ifdef CRAPS_STATS_EN
                            if (games_won_reg != 8'hFF)
                                games_won_reg <= games_won_reg + 8'd1;
`endif
                        end else if (sum_reg == 4'd7) begin
                            state_reg <= ST_LOSE;
                            phase_reg <= PH_LOSE;
                            loss_reg  <= 1'b1;
`ifdef CRAPS_STATS_EN
                            if (games_lost_reg != 8'hFF)
                                games_lost_reg <= games_lost_reg + 8'd1;
`endif
                        end else begin
                            state_reg <= ST_POINT;
                        end
                    end else begin
                        if (sum_reg == 4'd7 || sum_reg == 4'd11) begin
                            state_reg <= ST_WIN;
                            phase_reg <= PH_WIN;
                            win_reg   <= 1'b1;
`ifdef CRAPS_STATS_EN
                            if (games_won_reg != 8'hFF)
                                games_won_reg <= games_won_reg + 8'd1;
`endif
                        end else if (sum_reg == 4'd2 || sum_reg == 4'd3 ||
                                     sum_reg == 4'd12) begin
                            state_reg <= ST_LOSE;
                            phase_reg <= PH_LOSE;
                            loss_reg  <= 1'b1;
`ifdef CRAPS_STATS_EN
                            if (games_lost_reg != 8'hFF)
                                games_lost_reg <= games_lost_reg + 8'd1;
`endif
                        end else begin
                            state_reg <= ST_POINT;
                            phase_reg <= PH_POINT;
                            point_reg <= sum_reg;
                        end
                    end
                end

                default: begin
                    // An unreachable encoding falls back to a clean come-out.
                    state_reg <= ST_COMEOUT;
                    phase_reg <= PH_COMEOUT;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign disp_a     = disp_a_reg;
    assign disp_b     = disp_b_reg;
    assign point      = point_reg;
    assign phase      = phase_reg;
    assign win        = win_reg;
    assign loss       = loss_reg;
    assign busy       = busy_reg;
    assign bad_sample = bad_sample_reg;
    assign roll_count = roll_count_reg;
`ifdef CRAPS_STATS_EN
    assign games_won  = games_won_reg;
    assign games_lost = games_lost_reg;
`endif

endmodule

// File: tb/tb_craps_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_craps_round_sequencer
//
// Drives directed game scenarios, then randomized button and dice activity,
// into craps_round_sequencer. A behavioural reference model of the game rules
// predicts every output on every cycle. Directed scenarios also check
// literal, hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_craps_round_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int CW   = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          roll  = 1'b0;
    logic [2:0]    die_a = 3'd1;
    logic [2:0]    die_b = 3'd1;
    logic [2:0]    disp_a, disp_b;
    logic [3:0]    point;
    logic [1:0]    phase;
    logic          win, loss, busy, bad_sample;
    logic [CW-1:0] roll_count;
`ifdef CRAPS_STATS_EN
    logic [7:0]    games_won, games_lost;
`endif

    craps_round_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .roll      (roll),
        .die_a     (die_a),
        .die_b     (die_b),
        .disp_a    (disp_a),
        .disp_b    (disp_b),
        .point     (point),
        .phase     (phase),
        .win       (win),
        .loss      (loss),
        .busy      (busy),
        .bad_sample(bad_sample),
        .roll_count(roll_count)
`ifdef CRAPS_STATS_EN
        ,
        .games_won (games_won),
        .games_lost(games_lost)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model.
    // The button history is a queue of the raw values seen at each edge. The
    // debouncer sees the value from SYNC edges earlier, and it accepts a new
    // level after DEB consecutive disagreeing samples. Game rules are written
    // as plain arithmetic on the phase number: 0 come-out, 1 point, 2 win,
    // 3 lose.
    // -----------------------------------------------------------------------
    bit q_hist[$];
    int m_level, m_run;
    int m_disp_a, m_disp_b, m_point, m_phase, m_win, m_loss;
    int m_busy, m_bad, m_cnt, m_sum, m_eval;
    int m_won, m_lost;
    int m_presses;

    task automatic model_reset();
        q_hist.delete();
        m_level = 0; m_run = 0;
        m_disp_a = 7; m_disp_b = 7; m_point = 0; m_phase = 0;
        m_win = 0; m_loss = 0; m_busy = 0; m_bad = 0; m_cnt = 0;
        m_sum = 0; m_eval = 0; m_won = 0; m_lost = 0;
    endtask

    function automatic bit legal(input int d);
        return d >= 1 && d <= 6;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            int x;
            bit press;
            x = (q_hist.size() >= SYNC) ? int'(q_hist[q_hist.size() - SYNC]) : 0;
            q_hist.push_back(roll);
            if (q_hist.size() > SYNC) void'(q_hist.pop_front());
            press = 0;
            if (x != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    press   = (x == 1);
                    m_level = x;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end

            m_bad = 0;
            if (m_eval) begin
                m_eval = 0;
                m_busy = 0;
                if (m_phase == 1) begin
                    if (m_sum == m_point) begin m_phase = 2; m_win = 1; end
                    else if (m_sum == 7) begin m_phase = 3; m_loss = 1; end
                end else begin
                    if (m_sum == 7 || m_sum == 11) begin m_phase = 2; m_win = 1; end
                    else if (m_sum == 2 || m_sum == 3 || m_sum == 12) begin m_phase = 3; m_loss = 1; end
                    else begin m_phase = 1; m_point = m_sum; end
                end
                if (m_phase == 2 && m_win == 1 && m_loss == 0 && m_sum >= 0) begin end
            end else if (press) begin
                m_presses++;
                if (!legal(die_a) || !legal(die_b)) begin
                    m_bad = 1;
                end else begin
                    if (m_phase >= 2) begin
                        m_phase = 0; m_point = 0; m_win = 0; m_loss = 0; m_cnt = 0;
                    end
                    m_disp_a = die_a;
                    m_disp_b = die_b;
                    m_sum    = die_a + die_b;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    m_eval = 1;
                    m_busy = 1;
                end
            end
        end
    end

    // Stats follow the model's outcome transitions.
    int prev_win = 0, prev_loss = 0;
    always @(posedge clock or negedge reset) begin
        #0;
        if (!reset) begin
            prev_win = 0; prev_loss = 0;
        end else begin
            if (m_win && !prev_win && m_won < 255) m_won++;
            if (m_loss && !prev_loss && m_lost < 255) m_lost++;
            prev_win = m_win; prev_loss = m_loss;
        end
    end

    // -----------------------------------------------------------------------
    // Every-cycle compare of DUT against model, plus monitors for pulse counts
    // -----------------------------------------------------------------------
    bit cmp_en = 0;
    int busy_cycles = 0;
    int bad_pulses  = 0;

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("disp_a", int'(disp_a), m_disp_a);
            chk("disp_b", int'(disp_b), m_disp_b);
            chk("point", int'(point), m_point);
            chk("phase", int'(phase), m_phase);
            chk("win", int'(win), m_win);
            chk("loss", int'(loss), m_loss);
            chk("busy", int'(busy), m_busy);
            chk("bad_sample", int'(bad_sample), m_bad);
            chk("roll_count", int'(roll_count), m_cnt);
`ifdef CRAPS_STATS_EN
            chk("games_won", int'(games_won), m_won);
            chk("games_lost", int'(games_lost), m_lost);
`endif
        end
        if (busy) busy_cycles++;
        if (bad_sample) bad_pulses++;
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    function automatic logic [2:0] rand_die();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 3'(r % 6 + 1);
        return (r == 8) ? 3'd0 : 3'd7;
    endfunction

    task automatic hold_roll(input int hi, input int lo, input bit rnd_dice);
        for (int i = 0; i < hi; i++) begin
            @(negedge clock);
            roll = 1'b1;
            if (rnd_dice) begin die_a = rand_die(); die_b = rand_die(); end
        end
        for (int i = 0; i < lo; i++) begin
            @(negedge clock);
            roll = 1'b0;
            if (rnd_dice) begin die_a = rand_die(); die_b = rand_die(); end
        end
    endtask

    task automatic press(input int a, input int b);
        die_a = 3'(a);
        die_b = 3'(b);
        hold_roll(DEB + 5, DEB + 8, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clock);
        cmp_en = 1;
        do_reset();

        // Reset values
        chk("rst_disp_a", int'(disp_a), 7);
        chk("rst_disp_b", int'(disp_b), 7);
        chk("rst_phase", int'(phase), 0);
        chk("rst_point", int'(point), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_loss", int'(loss), 0);
        chk("rst_count", int'(roll_count), 0);

        // Come-out win 3+4
        busy_cycles = 0;
        press(3, 4);
        chk("co_win_disp_a", int'(disp_a), 3);
        chk("co_win_disp_b", int'(disp_b), 4);
        chk("co_win_phase", int'(phase), 2);
        chk("co_win_win", int'(win), 1);
        chk("co_win_count", int'(roll_count), 1);
        chk("co_win_busy_cycles", busy_cycles, 1);
        chk("model_pin_win", m_win, 1);

        // Point game: 2+2, 5+1, 3+1 -> win
        press(2, 2);
        chk("pt_point", int'(point), 4);
        chk("pt_phase", int'(phase), 1);
        chk("pt_count1", int'(roll_count), 1);
        chk("model_pin_point", m_point, 4);
        press(5, 1);
        chk("pt_stay_phase", int'(phase), 1);
        chk("pt_count2", int'(roll_count), 2);
        press(3, 1);
        chk("pt_made_win", int'(win), 1);
        chk("pt_made_phase", int'(phase), 2);

        // Point 4, then seven out
        press(2, 2);
        press(6, 1);
        chk("seven_out_loss", int'(loss), 1);
        chk("seven_out_phase", int'(phase), 3);
        chk("seven_out_point", int'(point), 4);
        chk("model_pin_loss", m_loss, 1);

        // New game from LOSE with 6+5
        press(6, 5);
        chk("newgame_win", int'(win), 1);
        chk("newgame_loss", int'(loss), 0);
        chk("newgame_count", int'(roll_count), 1);

        // Debounce: short pulse must not capture, long one captures once
        press(2, 2);
        die_a = 3'd3; die_b = 3'd3;
        hold_roll(DEB - 1, DEB + 8, 1'b0);
        chk("deb_short_count", int'(roll_count), 1);
        chk("deb_short_disp_a", int'(disp_a), 2);
        hold_roll(DEB + 5, DEB + 8, 1'b0);
        chk("deb_long_count", int'(roll_count), 2);
        chk("deb_long_disp_a", int'(disp_a), 3);

        // Invalid dice in come-out
        do_reset();
        bad_pulses = 0;
        press(0, 5);
        chk("bad_pulses", bad_pulses, 1);
        chk("bad_disp_a", int'(disp_a), 7);
        chk("bad_disp_b", int'(disp_b), 7);
        chk("bad_phase", int'(phase), 0);
        chk("bad_count", int'(roll_count), 0);

        // Reset abort in EVAL
        begin
            int waited;
            die_a = 3'd3; die_b = 3'd4;
            @(negedge clock);
            roll = 1'b1;
            waited = 0;
            while (!m_busy && waited < 200) begin
                @(negedge clock);
                waited++;
            end
            chk("abort_reached_eval", int'(m_busy), 1);
            #1;
            roll  = 1'b0;
            reset = 1'b0;
            #2;
            reset = 1'b1;
            repeat (DEB + 8) @(negedge clock);
            chk("abort_phase", int'(phase), 0);
            chk("abort_win", int'(win), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_disp_a", int'(disp_a), 7);
            chk("abort_count", int'(roll_count), 0);
        end

`ifdef CRAPS_STATS_EN
        press(3, 4);
        press(1, 1);
        chk("stats_won", int'(games_won), 1);
        chk("stats_lost", int'(games_lost), 1);
`endif

        // Randomized phase
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clock);
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
            hold_roll($urandom_range(1, DEB + 10), $urandom_range(1, DEB + 10), 1'b1);
        end
        repeat (DEB + 8) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
